mem_port_arbiter: RTL and testbench

- Shares the single external memory bus between the Fetch stage (instruction reads) and the Memory stage (loads/stores).
- Sequences one outstanding bus transaction at a time.
- Returns registered read data to the requesting stage.
- Drives stall requests that the pipeline ORs with the hazard-unit stalls.
- Includes a bus-timeout watchdog so a dead slave cannot hang the core.

---
 rtl/osiris_i_pkg.sv | 13 +
 rtl/mem_port_arbiter_bus_timeout_cnt.sv | 26 ++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/osiris_i_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package osiris_i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS_I = 2'd1,
    ST_BUS_D = 2'd2
  } arb_state_e;

  // Read data returned to the owner when the bus transaction is aborted.
  localparam int BUS_ERR_DATA = 0;

endpackage

// File: rtl/mem_port_arbiter_bus_timeout_cnt.sv
// Watchdog counter: counts unacknowledged bus cycles and pulses expired on
// the cycle in which the count reaches TIMEOUT_CYCLES.
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  // Fires during the last allowed cycle so the abort lands exactly after it.
  assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing the external memory bus between the
// Fetch and Memory stages, with fixed MEM priority and a bus watchdog.
module mem_port_arbiter
  import osiris_i_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_if_req,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  output logic                    o_if_valid,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  input  logic                    i_mem_req,
  input  logic                    i_mem_we,
  input  logic [DATA_WIDTH/8-1:0] i_mem_be,
  input  logic [ADDR_WIDTH-1:0]   i_mem_addr,
  input  logic [DATA_WIDTH-1:0]   i_mem_wdata,
  output logic                    o_mem_valid,
  output logic [DATA_WIDTH-1:0]   o_mem_rdata,
  output logic                    o_stall_IF,
  output logic                    o_stall_M,
  output logic                    o_bus_req,
  output logic                    o_bus_we,
  output logic [DATA_WIDTH/8-1:0] o_bus_be,
  output logic [ADDR_WIDTH-1:0]   o_bus_addr,
  output logic [DATA_WIDTH-1:0]   o_bus_wdata,
  input  logic                    i_bus_ack,
  input  logic [DATA_WIDTH-1:0]   i_bus_rdata,
  output logic                    o_bus_err
);

  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(BUS_ERR_DATA);

  arb_state_e state;
  logic       tmo_clear, tmo_en, tmo_expired;

  assign tmo_clear = (state == ST_IDLE);
  assign tmo_en    = (state != ST_IDLE) && !i_bus_ack;

  bus_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  // Gated by reset so every output reads 0 while the core is held in reset.
  assign o_stall_IF = i_rst_n & i_if_req  & ~o_if_valid;
  assign o_stall_M  = i_rst_n & i_mem_req & ~o_mem_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_be    <= '0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_err   <= 1'b0;
      o_if_valid  <= 1'b0;
      o_if_rdata  <= '0;
      o_mem_valid <= 1'b0;
      o_mem_rdata <= '0;
    end else begin
      o_if_valid  <= 1'b0;
      o_mem_valid <= 1'b0;
      o_bus_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A requester already being answered this cycle is not re-granted.
          if (i_mem_req && !o_mem_valid) begin
            state       <= ST_BUS_D;
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_mem_we;
            o_bus_be    <= i_mem_be;
            o_bus_addr  <= i_mem_addr;
            o_bus_wdata <= i_mem_wdata;
          end else if (i_if_req && !o_if_valid) begin
            state       <= ST_BUS_I;
            o_bus_req   <= 1'b1;
            o_bus_we    <= 1'b0;
            o_bus_be    <= '1;
            o_bus_addr  <= i_if_addr;
            o_bus_wdata <= '0;
          end
        end
        ST_BUS_I, ST_BUS_D: begin
          // Ack takes precedence over a watchdog expiry in the same cycle.
          if (i_bus_ack || tmo_expired) begin
            state     <= ST_IDLE;
            o_bus_req <= 1'b0;
            o_bus_err <= !i_bus_ack;
            if (state == ST_BUS_D) begin
              o_mem_valid <= 1'b1;
              o_mem_rdata <= (i_bus_ack && !o_bus_we) ? i_bus_rdata : ERR_DATA;
            end else begin
              o_if_valid  <= 1'b1;
              o_if_rdata  <= i_bus_ack ? i_bus_rdata : ERR_DATA;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          o_bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; each task drives one scenario and
// checks outputs 1 time unit after the rising edge.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_valid;
  logic [DW-1:0] o_if_rdata;
  logic          i_mem_req;
  logic          i_mem_we;
  logic [3:0]    i_mem_be;
  logic [AW-1:0] i_mem_addr;
  logic [DW-1:0] i_mem_wdata;
  logic          o_mem_valid;
  logic [DW-1:0] o_mem_rdata;
  logic          o_stall_IF, o_stall_M;
  logic          o_bus_req, o_bus_we;
  logic [3:0]    o_bus_be;
  logic [AW-1:0] o_bus_addr;
  logic [DW-1:0] o_bus_wdata;
  logic          i_bus_ack;
  logic [DW-1:0] i_bus_rdata;
  logic          o_bus_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_be(i_mem_be),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .o_mem_valid(o_mem_valid), .o_mem_rdata(o_mem_rdata),
    .o_stall_IF(o_stall_IF), .o_stall_M(o_stall_M),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_be(o_bus_be),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h10; i_mem_req = 1'b1;
    i_mem_we = 1'b0; i_mem_be = 4'h0; i_mem_addr = 32'h20; i_mem_wdata = '0;
    i_bus_ack = 1'b1; i_bus_rdata = 32'h1111_2222;
    tick(); tick();
    total_cnt++;
    if ({o_if_valid, o_mem_valid, o_stall_IF, o_stall_M, o_bus_req, o_bus_we, o_bus_err} !== 7'b0 ||
        o_if_rdata !== '0 || o_mem_rdata !== '0 || o_bus_be !== '0 || o_bus_addr !== '0 || o_bus_wdata !== '0)
      $display("FAIL reset_outputs: bus_req=%b stall_IF=%b stall_M=%b addr=%h expected all zero",
               o_bus_req, o_stall_IF, o_stall_M, o_bus_addr);
    else pass_cnt++;
    i_if_req = 1'b0; i_mem_req = 1'b0; i_bus_ack = 1'b0;
    i_rst_n = 1'b1;
    tick();
    // Unsolicited ack in IDLE must be ignored.
    i_bus_ack = 1'b1;
    tick();
    i_bus_ack = 1'b0;
    tick();
    total_cnt++;
    if (o_bus_req !== 1'b0 || o_if_valid !== 1'b0 || o_mem_valid !== 1'b0)
      $display("FAIL idle_stray_ack: req=%b ifv=%b memv=%b expected 0 0 0", o_bus_req, o_if_valid, o_mem_valid);
    else pass_cnt++;
  endtask

  task automatic test_single_fetch();
    i_if_req = 1'b1; i_if_addr = 32'h100;
    tick();
    total_cnt++;
    if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h100 || o_bus_we !== 1'b0 || o_bus_be !== 4'hF)
      $display("FAIL fetch_bus: req=%b addr=%h we=%b be=%h expected 1 00000100 0 f", o_bus_req, o_bus_addr, o_bus_we, o_bus_be);
    else pass_cnt++;
    total_cnt++;
    if (o_stall_IF !== 1'b1 || o_if_valid !== 1'b0)
      $display("FAIL fetch_stall_wait: stall=%b valid=%b expected 1 0", o_stall_IF, o_if_valid);
    else pass_cnt++;
    tick();
    i_bus_ack = 1'b1; i_bus_rdata = 32'hDEAD_BEEF;
    tick();
    i_bus_ack = 1'b0;
    total_cnt++;
    if (o_if_valid !== 1'b1 || o_if_rdata !== 32'hDEAD_BEEF)
      $display("FAIL fetch_valid: valid=%b rdata=%h expected 1 deadbeef", o_if_valid, o_if_rdata);
    else pass_cnt++;
    total_cnt++;
    if (o_stall_IF !== 1'b0 || o_bus_req !== 1'b0)
      $display("FAIL fetch_valid_cycle: stall=%b req=%b expected 0 0", o_stall_IF, o_bus_req);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (o_if_valid !== 1'b0 || o_bus_req !== 1'b0)
      $display("FAIL fetch_single_pulse: valid=%b req=%b expected 0 0 (no regrant while valid)", o_if_valid, o_bus_req);
    else pass_cnt++;
    i_if_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    i_if_req = 1'b1; i_if_addr = 32'h200;
    i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_be = 4'hF; i_mem_addr = 32'h8000;
    tick();
    total_cnt++;
    if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h8000 || o_stall_IF !== 1'b1 || o_stall_M !== 1'b1)
      $display("FAIL sim_mem_first: req=%b addr=%h stIF=%b stM=%b expected 1 00008000 1 1",
               o_bus_req, o_bus_addr, o_stall_IF, o_stall_M);
    else pass_cnt++;
    i_bus_ack = 1'b1; i_bus_rdata = 32'hA5A5_0001;
    tick();
    i_bus_ack = 1'b0; i_mem_req = 1'b0;
    total_cnt++;
    if (o_mem_valid !== 1'b1 || o_mem_rdata !== 32'hA5A5_0001 || o_if_valid !== 1'b0)
      $display("FAIL sim_mem_valid: memv=%b rdata=%h ifv=%b expected 1 a5a50001 0", o_mem_valid, o_mem_rdata, o_if_valid);
    else pass_cnt++;
    total_cnt++;
    if (o_stall_IF !== 1'b1 || o_bus_req !== 1'b0)
      $display("FAIL sim_if_waiting: stIF=%b req=%b expected 1 0", o_stall_IF, o_bus_req);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h200 || o_bus_we !== 1'b0 || o_stall_IF !== 1'b1)
      $display("FAIL sim_if_grant: req=%b addr=%h we=%b stIF=%b expected 1 00000200 0 1",
               o_bus_req, o_bus_addr, o_bus_we, o_stall_IF);
    else pass_cnt++;
    i_bus_ack = 1'b1; i_bus_rdata = 32'h0BAD_F00D;
    tick();
    i_bus_ack = 1'b0;
    total_cnt++;
    if (o_if_valid !== 1'b1 || o_if_rdata !== 32'h0BAD_F00D || o_mem_valid !== 1'b0)
      $display("FAIL sim_if_valid: ifv=%b rdata=%h memv=%b expected 1 0badf00d 0", o_if_valid, o_if_rdata, o_mem_valid);
    else pass_cnt++;
    i_if_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_be = 4'hF; i_mem_addr = 32'h300;
    tick();
    for (int i = 0; i < TMO; i++) begin
      total_cnt++;
      if (o_bus_req !== 1'b1 || o_bus_err !== 1'b0 || o_mem_valid !== 1'b0)
        $display("FAIL tmo_wait_%0d: req=%b err=%b memv=%b expected 1 0 0", i, o_bus_req, o_bus_err, o_mem_valid);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (o_bus_req !== 1'b0 || o_bus_err !== 1'b1 || o_mem_valid !== 1'b1 || o_mem_rdata !== 32'h0)
      $display("FAIL tmo_abort: req=%b err=%b memv=%b rdata=%h expected 0 1 1 00000000",
               o_bus_req, o_bus_err, o_mem_valid, o_mem_rdata);
    else pass_cnt++;
    i_mem_req = 1'b0;
    tick();
    total_cnt++;
    if (o_bus_err !== 1'b0 || o_mem_valid !== 1'b0 || o_bus_req !== 1'b0)
      $display("FAIL tmo_idle: err=%b memv=%b req=%b expected 0 0 0", o_bus_err, o_mem_valid, o_bus_req);
    else pass_cnt++;
  endtask

  task automatic test_ack_at_timeout();
    i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h500;
    tick();
    tick(); tick(); tick();
    total_cnt++;
    if (o_bus_req !== 1'b1)
      $display("FAIL ackt_still_req: req=%b expected 1", o_bus_req);
    else pass_cnt++;
    i_bus_ack = 1'b1; i_bus_rdata = 32'h7777_8888;
    tick();
    i_bus_ack = 1'b0;
    total_cnt++;
    if (o_mem_valid !== 1'b1 || o_mem_rdata !== 32'h7777_8888 || o_bus_err !== 1'b0)
      $display("FAIL ackt_resp: memv=%b rdata=%h err=%b expected 1 77778888 0", o_mem_valid, o_mem_rdata, o_bus_err);
    else pass_cnt++;
    i_mem_req = 1'b0;
    tick();
    total_cnt++;
    if (o_bus_err !== 1'b0 || o_bus_req !== 1'b0)
      $display("FAIL ackt_after: err=%b req=%b expected 0 0", o_bus_err, o_bus_req);
    else pass_cnt++;
  endtask

  task automatic test_store();
    i_mem_req = 1'b1; i_mem_we = 1'b1; i_mem_be = 4'b0011;
    i_mem_addr = 32'h40; i_mem_wdata = 32'h1234_5678;
    tick();
    total_cnt++;
    if (o_bus_req !== 1'b1 || o_bus_we !== 1'b1 || o_bus_be !== 4'b0011 ||
        o_bus_addr !== 32'h40 || o_bus_wdata !== 32'h1234_5678)
      $display("FAIL store_bus: req=%b we=%b be=%b addr=%h wdata=%h expected 1 1 0011 00000040 12345678",
               o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata);
    else pass_cnt++;
    i_mem_wdata = 32'hFFFF_FFFF; i_mem_addr = 32'hFFFF_FFF0;
    tick();
    total_cnt++;
    if (o_bus_wdata !== 32'h1234_5678 || o_bus_addr !== 32'h40 || o_bus_be !== 4'b0011)
      $display("FAIL store_stable: wdata=%h addr=%h be=%b expected 12345678 00000040 0011", o_bus_wdata, o_bus_addr, o_bus_be);
    else pass_cnt++;
    i_bus_ack = 1'b1; i_bus_rdata = 32'hCAFE_BABE;
    tick();
    i_bus_ack = 1'b0;
    total_cnt++;
    if (o_mem_valid !== 1'b1 || o_mem_rdata !== 32'h0 || o_bus_err !== 1'b0)
      $display("FAIL store_resp: memv=%b rdata=%h err=%b expected 1 00000000 0", o_mem_valid, o_mem_rdata, o_bus_err);
    else pass_cnt++;
    i_mem_req = 1'b0; i_mem_we = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    i_if_req = 1'b1; i_if_addr = 32'h600;
    tick();
    total_cnt++;
    if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h600)
      $display("FAIL rstmid_grant: req=%b addr=%h expected 1 00000600", o_bus_req, o_bus_addr);
    else pass_cnt++;
    #2 i_rst_n = 1'b0;
    #1;
    total_cnt++;
    if (o_bus_req !== 1'b0 || o_stall_IF !== 1'b0 || o_if_valid !== 1'b0)
      $display("FAIL rstmid_async: req=%b stIF=%b ifv=%b expected 0 0 0", o_bus_req, o_stall_IF, o_if_valid);
    else pass_cnt++;
    i_if_req = 1'b0;
    tick();
    i_rst_n = 1'b1;
    i_bus_ack = 1'b1; i_bus_rdata = 32'h5555_AAAA;
    tick();
    i_bus_ack = 1'b0;
    tick();
    total_cnt++;
    if (o_if_valid !== 1'b0 || o_bus_req !== 1'b0 || o_bus_err !== 1'b0)
      $display("FAIL rstmid_no_resp: ifv=%b req=%b err=%b expected 0 0 0", o_if_valid, o_bus_req, o_bus_err);
    else pass_cnt++;
    i_if_req = 1'b1; i_if_addr = 32'h700;
    tick();
    total_cnt++;
    if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h700)
      $display("FAIL rstmid_regrant: req=%b addr=%h expected 1 00000700", o_bus_req, o_bus_addr);
    else pass_cnt++;
    i_bus_ack = 1'b1; i_bus_rdata = 32'h3C3C_C3C3;
    tick();
    i_bus_ack = 1'b0;
    total_cnt++;
    if (o_if_valid !== 1'b1 || o_if_rdata !== 32'h3C3C_C3C3)
      $display("FAIL rstmid_resp: ifv=%b rdata=%h expected 1 3c3cc3c3", o_if_valid, o_if_rdata);
    else pass_cnt++;
    i_if_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_timeout();
    test_ack_at_timeout();
    test_store();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
